// File: rtl/dice_game_engine.sv
// rtl/dice_game_engine.sv - two-die craps controller with scores; optional DICE_EXT_SUM_EN takes the sum from sum_in
module dice_game_engine #(
    parameter int SIDES     = 6,
    parameter int WIN_A     = 7,
    parameter int WIN_B     = 11,
    parameter int LOSE_A    = 2,
    parameter int LOSE_B    = 3,
    parameter int LOSE_C    = 12,
    parameter int LOSE_PT   = 7,
    parameter int MAX_ROLLS = 0,
    parameter int CNT_W     = 8,
    localparam int SW       = $clog2(2*SIDES+1),
    localparam int DW       = $clog2(SIDES+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rb,
`ifdef DICE_EXT_SUM_EN
    input  logic [SW-1:0]    sum_in,
`endif
    output logic             roll,
    output logic             win,
    output logic             lose,
    output logic [2:0]       state,
    output logic [DW-1:0]    die1,
    output logic [DW-1:0]    die2,
    output logic [SW-1:0]    sum,
    output logic [SW-1:0]    point,
    output logic [CNT_W-1:0] roll_cnt,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_ROLL1 = 3'd1,
        S_POINT = 3'd2,
        S_ROLLN = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    localparam logic [SW-1:0]    WIN_A_S   = SW'(WIN_A);
    localparam logic [SW-1:0]    WIN_B_S   = SW'(WIN_B);
    localparam logic [SW-1:0]    LOSE_A_S  = SW'(LOSE_A);
    localparam logic [SW-1:0]    LOSE_B_S  = SW'(LOSE_B);
    localparam logic [SW-1:0]    LOSE_C_S  = SW'(LOSE_C);
    localparam logic [SW-1:0]    LOSE_PT_S = SW'(LOSE_PT);
    localparam logic [CNT_W-1:0] MAX_R_S   = CNT_W'(MAX_ROLLS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           st;
    logic             rb_q;
    logic             rise;
    logic             fall;
    logic [SW-1:0]    eval_sum;
    logic [CNT_W-1:0] cnt_inc;

    assign rise  = rb & ~rb_q;
    assign fall  = ~rb & rb_q;
    assign state = st;
    assign roll  = (st == S_ROLL1) || (st == S_ROLLN);

    // Point-phase roll counter saturates rather than wrapping back to zero
    assign cnt_inc = (roll_cnt == CNT_MAX) ? roll_cnt : roll_cnt + 1'b1;

`ifdef DICE_EXT_SUM_EN
    assign eval_sum = sum_in;
    assign die1     = '0;
    assign die2     = '0;
`else
    assign eval_sum = SW'(die1) + SW'(die2);

    // Dice behave as a two-digit odometer that spins while the button is held in a rolling state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            die1 <= DW'(1);
            die2 <= DW'(1);
        end else if (roll && rb) begin
            if (die1 == DW'(SIDES)) begin
                die1 <= DW'(1);
                die2 <= (die2 == DW'(SIDES)) ? DW'(1) : die2 + 1'b1;
            end else begin
                die1 <= die1 + 1'b1;
            end
        end
    end
`endif

    // Game FSM: starts rolls on button rise, evaluates on button fall, keeps scores across games
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= S_START;
            rb_q     <= 1'b0;
            win      <= 1'b0;
            lose     <= 1'b0;
            sum      <= '0;
            point    <= '0;
            roll_cnt <= '0;
            wins     <= '0;
            losses   <= '0;
        end else begin
            rb_q <= rb;
            case (st)
                S_START: if (rise) st <= S_ROLL1;
                S_POINT: if (rise) st <= S_ROLLN;
                S_WIN, S_LOSE: begin
                    if (rise) begin
                        win      <= 1'b0;
                        lose     <= 1'b0;
                        point    <= '0;
                        roll_cnt <= '0;
                        st       <= S_ROLL1;
                    end
                end
                S_ROLL1: begin
                    if (fall) begin
                        sum <= eval_sum;
                        if (eval_sum == WIN_A_S || eval_sum == WIN_B_S) begin
                            st  <= S_WIN;
                            win <= 1'b1;
                            if (wins != CNT_MAX) wins <= wins + 1'b1;
                        end else if (eval_sum == LOSE_A_S || eval_sum == LOSE_B_S ||
                                     eval_sum == LOSE_C_S) begin
                            st   <= S_LOSE;
                            lose <= 1'b1;
                            if (losses != CNT_MAX) losses <= losses + 1'b1;
                        end else begin
                            point <= eval_sum;
                            st    <= S_POINT;
                        end
                    end
                end
                S_ROLLN: begin
                    if (fall) begin
                        sum      <= eval_sum;
                        roll_cnt <= cnt_inc;
                        if (eval_sum == point) begin
                            st  <= S_WIN;
                            win <= 1'b1;
                            if (wins != CNT_MAX) wins <= wins + 1'b1;
                        end else if (eval_sum == LOSE_PT_S ||
                                     (MAX_ROLLS != 0 && cnt_inc == MAX_R_S)) begin
                            st   <= S_LOSE;
                            lose <= 1'b1;
                            if (losses != CNT_MAX) losses <= losses + 1'b1;
                        end else begin
                            st <= S_POINT;
                        end
                    end
                end
                default: st <= S_START;
            endcase
        end
    end

endmodule
